// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
// Optional signed-overflow output is enabled with SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder (ovf only with SERIAL_ADDER_OVF_EN).
// Both sides are valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
`else
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/serial_adder_full_adder.sv
// Single-bit full-adder cell, reused as the per-bit datapath of serial_adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus carry flop, LSB first, one bit per clock.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output and its carry-into-MSB flop.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus,
    output state_t        state_o
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder: WIDTH out of range");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_sum, fa_cout;
    logic             in_ready, out_valid;
`ifdef SERIAL_ADDER_OVF_EN
    logic             cmsb_q, cmsb_d;
`endif

    full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            cmsb_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            cmsb_q   <= cmsb_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_sh_d  = sum_sh_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        cmsb_d    = cmsb_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                // New sum bit enters at the MSB so bit 0 ends up at the LSB after WIDTH shifts.
                sum_sh_d = sum_sh_q >> 1;
                sum_sh_d[WIDTH-1] = fa_sum;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
`ifdef SERIAL_ADDER_OVF_EN
                    cmsb_d  = carry_q;
`endif
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sum       = sum_sh_q;
    assign bus.cout      = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf       = cmsb_q ^ carry_q;
`endif
    assign state_o       = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances against an arithmetic model.
// ovf is checked only when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;
    import serial_adder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();
    state_t st8, st1;

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8), .state_o(st8));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .state_o(st1));

    int n_checks = 0;
    int n_errors = 0;
    logic [9:0] exp8_q[$];
    logic [2:0] exp1_q[$];
    logic [9:0] e8;
    logic [2:0] e1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer addition; signed overflow from operand/result signs.
    function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + {8'd0, c};
        return {(a[7] == b[7]) && (s[7] != a[7]), s};
    endfunction

    function automatic logic [2:0] ref1(input logic a, input logic b, input logic c);
        logic [1:0] s;
        s = {1'b0, a} + {1'b0, b} + {1'b0, c};
        return {(a == b) && (s[0] != a), s};
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus8.out_valid && bus8.out_ready) begin
            if (exp8_q.size() == 0) begin
                check("spurious8", 64'(bus8.out_valid), 64'(1'b0));
            end else begin
                e8 = exp8_q.pop_front();
                check("sum8", 64'(bus8.sum), 64'(e8[7:0]));
                check("cout8", 64'(bus8.cout), 64'(e8[8]));
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf8", 64'(bus8.ovf), 64'(e8[9]));
`endif
            end
        end
        if (rst_n && bus1.out_valid && bus1.out_ready) begin
            if (exp1_q.size() == 0) begin
                check("spurious1", 64'(bus1.out_valid), 64'(1'b0));
            end else begin
                e1 = exp1_q.pop_front();
                check("sum1", 64'(bus1.sum), 64'(e1[0]));
                check("cout1", 64'(bus1.cout), 64'(e1[1]));
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf1", 64'(bus1.ovf), 64'(e1[2]));
`endif
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 (after the output rises when wait_out is set).
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input bit push, input bit wait_out);
        int g;
        int lat;
        bus8.a = a; bus8.b = b; bus8.cin = c; bus8.in_valid = 1'b1;
        g = 0;
        while (!bus8.in_ready && g < 200) begin
            @(posedge clk); #1; g++;
        end
        if (g >= 200) check("in_ready_timeout8", 64'(bus8.in_ready), 64'(1'b1));
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
        if (push) exp8_q.push_back(ref8(a, b, c));
        if (wait_out) begin
            lat = 0;
            do begin
                @(posedge clk); #1; lat++;
            end while (!bus8.out_valid && lat < 100);
            check("latency8", 64'(lat), 64'(8));
        end
    endtask

    task automatic drain8(input int stall);
        repeat (stall) begin @(posedge clk); #1; end
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
    endtask

    task automatic send1(input logic a, input logic b, input logic c);
        int lat;
        bus1.a = a; bus1.b = b; bus1.cin = c; bus1.in_valid = 1'b1;
        check("in_ready1", 64'(bus1.in_ready), 64'(1'b1));
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        exp1_q.push_back(ref1(a, b, c));
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!bus1.out_valid && lat < 100);
        check("latency1", 64'(lat), 64'(1));
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] e;
        logic [2:0] v;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus8.out_valid), 64'(1'b0));
        check("rst_in_ready", 64'(bus8.in_ready), 64'(1'b1));
        check("rst_sum", 64'(bus8.sum), 64'(8'h00));
        check("rst_cout", 64'(bus8.cout), 64'(1'b0));
        check("rst_state", 64'(st8), 64'(IDLE));
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", 64'(bus8.ovf), 64'(1'b0));
`endif
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        send8(8'h5A, 8'h3C, 1'b0, 1, 1); drain8(0);
        send8(8'hFF, 8'h01, 1'b0, 1, 1); drain8(1);
        send8(8'h7F, 8'h00, 1'b1, 1, 1); drain8(0);

        // Backpressure: result held, inputs ignored while in DONE
        send8(8'h12, 8'h34, 1'b1, 1, 1);
        e = ref8(8'h12, 8'h34, 1'b1);
        for (int k = 0; k < 10; k++) begin
            bus8.in_valid = 1'($urandom_range(0, 1));
            bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
            @(posedge clk); #1;
            check("bp_sum", 64'(bus8.sum), 64'(e[7:0]));
            check("bp_cout", 64'(bus8.cout), 64'(e[8]));
            check("bp_in_ready", 64'(bus8.in_ready), 64'(1'b0));
            check("bp_out_valid", 64'(bus8.out_valid), 64'(1'b1));
        end
        // Output handshake and input valid together: input waits for IDLE
        bus8.in_valid = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b1;
        bus8.out_ready = 1'b1;
        check("ovl_in_ready_done", 64'(bus8.in_ready), 64'(1'b0));
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        check("ovl_in_ready_idle", 64'(bus8.in_ready), 64'(1'b1));
        check("ovl_state_idle", 64'(st8), 64'(IDLE));
        bus8.in_valid = 1'b0;
        send8(8'hAA, 8'h55, 1'b1, 1, 1); drain8(0);

        // Reset during SHIFT discards the partial result
        send8(8'hFF, 8'hFF, 1'b1, 0, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(bus8.out_valid), 64'(1'b0));
        check("mid_rst_in_ready", 64'(bus8.in_ready), 64'(1'b1));
        check("mid_rst_sum", 64'(bus8.sum), 64'(8'h00));
        check("mid_rst_cout", 64'(bus8.cout), 64'(1'b0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send8(8'h01, 8'h01, 1'b0, 1, 1); drain8(2);

        // Random traffic
        for (int k = 0; k < 20; k++) begin
            send8(8'($urandom), 8'($urandom), 1'($urandom), 1, 1);
            drain8($urandom_range(0, 3));
        end

        // WIDTH=1: exhaustive
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            send1(v[2], v[1], v[0]);
        end

        repeat (2) @(posedge clk);
        #1;
        check("leftover8", 64'(exp8_q.size()), 64'(0));
        check("leftover1", 64'(exp1_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
